ether_axil_arb: RTL

ETHER_AXIL_ARB -- requirements
Module: ether_axil_arb

---
 rtl/ether_axil_arb.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/ether_axil_arb.sv
// Two-port command arbiter in front of a single AXI4-Lite master.
// One transaction in flight; the granted requester gets a one-cycle
// response pulse when the bus transaction completes.
//
//   state   | meaning
//   --------+-------------------------------------------------
//   IDLE    | waiting for a request; grant issued here
//   WR_REQ  | AW and W channels presented, awaiting handshakes
//   WR_RESP | bready high, awaiting bvalid
//   RD_REQ  | AR channel presented, awaiting arready
//   RD_DATA | rready high, awaiting rvalid
//   DONE    | rsp_valid pulse to the granted port
module ether_axil_arb #(
   parameter int unsigned RR = 1
) (
   input  logic        sys_clk,
   input  logic        rst,

   input  logic        p0_req_valid,
   output logic        p0_req_ready,
   input  logic        p0_req_we,
   input  logic [31:0] p0_req_addr,
   input  logic [31:0] p0_req_wdata,
   input  logic [3:0]  p0_req_wstrb,
   output logic        p0_rsp_valid,
   output logic [31:0] p0_rsp_rdata,
   output logic [1:0]  p0_rsp_resp,

   input  logic        p1_req_valid,
   output logic        p1_req_ready,
   input  logic        p1_req_we,
   input  logic [31:0] p1_req_addr,
   input  logic [31:0] p1_req_wdata,
   input  logic [3:0]  p1_req_wstrb,
   output logic        p1_rsp_valid,
   output logic [31:0] p1_rsp_rdata,
   output logic [1:0]  p1_rsp_resp,

   output logic [31:0] awaddr,
   output logic        awvalid,
   input  logic        awready,
   output logic [31:0] wdata,
   output logic [3:0]  wstrb,
   output logic        wvalid,
   input  logic        wready,
   input  logic [1:0]  bresp,
   input  logic        bvalid,
   output logic        bready,
   output logic [31:0] araddr,
   output logic        arvalid,
   input  logic        arready,
   input  logic [31:0] rdata,
   input  logic [1:0]  rresp,
   input  logic        rvalid,
   output logic        rready
);

   typedef enum logic [2:0] {
      IDLE, WR_REQ, WR_RESP, RD_REQ, RD_DATA, DONE
   } state_t;

   state_t      state_q;
   logic        gnt_q;
   logic        last_q;
   logic [31:0] addr_q;
   logic [31:0] wdata_q;
   logic [3:0]  wstrb_q;
   logic        awvalid_q;
   logic        wvalid_q;
   logic        bready_q;
   logic        arvalid_q;
   logic        rready_q;
   logic [1:0]  rsp_valid_q;
   logic [31:0] rsp_rdata_q;
   logic [1:0]  rsp_resp_q;

   logic        gnt_d;
   logic        any_req;
   logic        grant_fire;
   logic        sel_we;
   logic [31:0] sel_addr;
   logic [31:0] sel_wdata;
   logic [3:0]  sel_wstrb;
   logic        aw_fin;
   logic        w_fin;

   // Arbitration and the combinational accept pulse in IDLE.
   always_comb begin
      any_req = p0_req_valid | p1_req_valid;
      if (p0_req_valid && p1_req_valid)
         gnt_d = (RR != 0) ? ~last_q : 1'b0;
      else
         gnt_d = p1_req_valid;
      grant_fire   = (state_q == IDLE) && any_req && !rst;
      p0_req_ready = grant_fire && !gnt_d;
      p1_req_ready = grant_fire && gnt_d;
      sel_we    = gnt_d ? p1_req_we    : p0_req_we;
      sel_addr  = gnt_d ? p1_req_addr  : p0_req_addr;
      sel_wdata = gnt_d ? p1_req_wdata : p0_req_wdata;
      sel_wstrb = gnt_d ? p1_req_wstrb : p0_req_wstrb;
      // A write channel is finished once its valid has dropped or is handshaking now.
      aw_fin = !awvalid_q || awready;
      w_fin  = !wvalid_q  || wready;
   end

   // Transaction sequencer with registered bus and response outputs.
   always_ff @(posedge sys_clk) begin
      if (rst) begin
         state_q     <= IDLE;
         gnt_q       <= 1'b0;
         last_q      <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         wstrb_q     <= '0;
         awvalid_q   <= 1'b0;
         wvalid_q    <= 1'b0;
         bready_q    <= 1'b0;
         arvalid_q   <= 1'b0;
         rready_q    <= 1'b0;
         rsp_valid_q <= 2'b00;
         rsp_rdata_q <= '0;
         rsp_resp_q  <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (any_req) begin
                  gnt_q   <= gnt_d;
                  last_q  <= gnt_d;
                  addr_q  <= sel_addr;
                  wdata_q <= sel_wdata;
                  wstrb_q <= sel_wstrb;
                  if (sel_we) begin
                     awvalid_q <= 1'b1;
                     wvalid_q  <= 1'b1;
                     state_q   <= WR_REQ;
                  end else begin
                     arvalid_q <= 1'b1;
                     state_q   <= RD_REQ;
                  end
               end
            end
            WR_REQ: begin
               if (awvalid_q && awready) awvalid_q <= 1'b0;
               if (wvalid_q && wready)   wvalid_q  <= 1'b0;
               if (aw_fin && w_fin) begin
                  bready_q <= 1'b1;
                  state_q  <= WR_RESP;
               end
            end
            WR_RESP: begin
               if (bvalid) begin
                  bready_q    <= 1'b0;
                  rsp_resp_q  <= bresp;
                  rsp_rdata_q <= '0;
                  rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                  state_q     <= DONE;
               end
            end
            RD_REQ: begin
               if (arready) begin
                  arvalid_q <= 1'b0;
                  rready_q  <= 1'b1;
                  state_q   <= RD_DATA;
               end
            end
            RD_DATA: begin
               if (rvalid) begin
                  rready_q    <= 1'b0;
                  rsp_resp_q  <= rresp;
                  rsp_rdata_q <= rdata;
                  rsp_valid_q <= gnt_q ? 2'b10 : 2'b01;
                  state_q     <= DONE;
               end
            end
            DONE: begin
               rsp_valid_q <= 2'b00;
               state_q     <= IDLE;
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   // Bus outputs straight from registers; responses gated per port so the idle port reads 0.
   always_comb begin
      awaddr  = addr_q;
      araddr  = addr_q;
      wdata   = wdata_q;
      wstrb   = wstrb_q;
      awvalid = awvalid_q;
      wvalid  = wvalid_q;
      bready  = bready_q;
      arvalid = arvalid_q;
      rready  = rready_q;
      p0_rsp_valid = rsp_valid_q[0] && !rst;
      p1_rsp_valid = rsp_valid_q[1] && !rst;
      p0_rsp_rdata = p0_rsp_valid ? rsp_rdata_q : '0;
      p1_rsp_rdata = p1_rsp_valid ? rsp_rdata_q : '0;
      p0_rsp_resp  = p0_rsp_valid ? rsp_resp_q  : '0;
      p1_rsp_resp  = p1_rsp_valid ? rsp_resp_q  : '0;
   end

endmodule
